// File: rtl/nn_pkg.sv
// Shared definitions for the neuron datapath blocks: FSM encoding,
// accumulator sizing and the default saturation limits.
package nn_pkg;

  // MAC sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } mac_state_e;

  // Accumulator width that can hold bias plus n full-scale products without wrapping.
  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + $clog2(n + 1) + 1;
  endfunction

  // Clamp limits of the double-width result at the default 16-bit data width.
  localparam logic [31:0] SAT_MAX_DEFAULT = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/neuron_mac_if.sv
// Stream bundle around the MAC core: (input, weight) beats in, pre-activation sum out.
//
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid && ready. Once valid is raised the producer holds valid and its
// payload stable until the transfer; ready may change freely and valid never
// depends combinationally on ready.
interface neuron_mac_if #(
  parameter int DATA_WIDTH = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   in_data;
  logic [DATA_WIDTH-1:0]   in_weight;
  logic                    out_valid;
  logic                    out_ready;
  logic [2*DATA_WIDTH-1:0] out_sum;

  // Environment side: feeds beats and consumes sums.
  modport master (
    output in_valid, in_data, in_weight, out_ready,
    input  in_ready, out_valid, out_sum
  );

  // Core side.
  modport slave (
    input  in_valid, in_data, in_weight, out_ready,
    output in_ready, out_valid, out_sum
  );
endinterface

// File: rtl/sat_clamp.sv
// Combinational signed clamp from a wide value into OUT_W bits.
// IN_W must be larger than OUT_W.
module sat_clamp #(
  parameter int IN_W  = 36,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  in_i,
  output logic [OUT_W-1:0] out_o
);

  // Bits that must all equal the sign bit for the value to fit in OUT_W.
  logic [IN_W-OUT_W:0] top_bits;

  assign top_bits = in_i[IN_W-1:OUT_W-1];

  // Pass through when representable, otherwise pick the limit on the sign side.
  always_comb begin
    out_o = in_i[OUT_W-1:0];
    if ((|top_bits) && !(&top_bits)) begin
      out_o = in_i[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Sequential multiply-accumulate core of one neuron. Streams num_inputs
// (input, weight) beats, adds their products onto a preloaded bias and
// offers the saturated double-width sum downstream.
module neuron_mac
  import nn_pkg::*;
#(
  parameter int data_width = 16,
  parameter int num_inputs = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [2*data_width-1:0]   bias,
  output logic                      busy,
  output mac_state_e                state_dbg_o,
  neuron_mac_if.slave               bus
);

  localparam int SUM_W = 2 * data_width;
  localparam int ACC_W = acc_width(data_width, num_inputs);
  localparam int CNT_W = $clog2(num_inputs + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(num_inputs - 1);

  mac_state_e              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [SUM_W-1:0] prod_q, prod_d;
  logic                    prod_vld_q, prod_vld_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SUM_W-1:0]        out_sum_q, out_sum_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;

  logic signed [data_width-1:0] in_data_s, in_weight_s;
  logic signed [SUM_W-1:0]      beat_prod;
  logic signed [ACC_W-1:0]      bias_ext, prod_ext, drain_sum;
  logic [SUM_W-1:0]             drain_sat;
  logic                         in_fire, out_fire;

  assign in_data_s   = $signed(bus.in_data);
  assign in_weight_s = $signed(bus.in_weight);
  // Full product fits in SUM_W bits, including (-2^(dw-1))^2.
  assign beat_prod   = SUM_W'(in_data_s) * SUM_W'(in_weight_s);
  assign bias_ext    = {{(ACC_W-SUM_W){bias[SUM_W-1]}}, bias};
  assign prod_ext    = {{(ACC_W-SUM_W){prod_q[SUM_W-1]}}, prod_q};
  // The last beat's product is still in flight when DRAIN is reached.
  assign drain_sum   = prod_vld_q ? (acc_q + prod_ext) : acc_q;

  assign in_fire  = bus.in_valid && in_ready_q;
  assign out_fire = out_valid_q && bus.out_ready;

  sat_clamp #(
    .IN_W (ACC_W),
    .OUT_W(SUM_W)
  ) u_sat (
    .in_i (drain_sum),
    .out_o(drain_sat)
  );

  // State and datapath registers; reset discards any partial evaluation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      prod_q      <= '0;
      prod_vld_q  <= 1'b0;
      cnt_q       <= '0;
      out_sum_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      prod_vld_q  <= prod_vld_d;
      cnt_q       <= cnt_d;
      out_sum_q   <= out_sum_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state, accumulate and output-register logic.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    prod_d      = prod_q;
    prod_vld_d  = 1'b0;
    cnt_d       = cnt_q;
    out_sum_d   = out_sum_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACC;
          acc_d   = bias_ext;
          cnt_d   = '0;
        end
      end
      ST_ACC: begin
        // Previous product folds in while the next beat is being taken.
        if (prod_vld_q) begin
          acc_d = acc_q + prod_ext;
        end
        if (in_fire) begin
          prod_d     = beat_prod;
          prod_vld_d = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        out_sum_d = drain_sat;
        state_d   = ST_OUT;
      end
      ST_OUT: begin
        if (out_fire) begin
          if (start) begin
            state_d = ST_ACC;
            acc_d   = bias_ext;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Handshake flags are registered copies of the upcoming state.
    in_ready_d  = (state_d == ST_ACC);
    out_valid_d = (state_d == ST_OUT);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign busy          = (state_q != ST_IDLE);
  assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac with data_width=16, num_inputs=4: table vectors,
// randomized evaluations against a plain-arithmetic model, and hand-written
// backpressure and mid-run reset sequences.
module tb_neuron_mac;
  import nn_pkg::*;

  typedef logic [3:0][15:0] beat_arr_t;
  typedef struct packed {
    logic [31:0] bias;
    beat_arr_t   d;
    beat_arr_t   w;
    logic [31:0] exp_sum;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] bias;
  logic        busy;
  mac_state_e  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  vec_t vecs[8];
  beat_arr_t basic_d, basic_w;

  neuron_mac_if #(.DATA_WIDTH(16)) bus ();

  neuron_mac #(
    .data_width(16),
    .num_inputs(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bias       (bias),
    .busy       (busy),
    .state_dbg_o(state_dbg),
    .bus        (bus.slave)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: run did not reach its summary in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: bias plus exact products in 64-bit arithmetic, then clamp.
  function automatic logic [31:0] ref_sum(input logic [31:0] b, input beat_arr_t d, input beat_arr_t w);
    longint s;
    longint hi;
    longint lo;
    hi = (longint'(1) <<< 31) - 1;
    lo = -(longint'(1) <<< 31);
    s = longint'($signed(b));
    for (int i = 0; i < 4; i++) begin
      s += longint'($signed(d[i])) * longint'($signed(w[i]));
    end
    if (s > hi) return 32'h7FFF_FFFF;
    if (s < lo) return 32'h8000_0000;
    return s[31:0];
  endfunction

  function automatic vec_t mk(input logic [31:0] b,
                              input logic [15:0] d0, input logic [15:0] w0,
                              input logic [15:0] d1, input logic [15:0] w1,
                              input logic [15:0] d2, input logic [15:0] w2,
                              input logic [15:0] d3, input logic [15:0] w3,
                              input logic [31:0] e);
    vec_t v;
    v.bias = b;
    v.d[0] = d0; v.w[0] = w0;
    v.d[1] = d1; v.w[1] = w1;
    v.d[2] = d2; v.w[2] = w2;
    v.d[3] = d3; v.w[3] = w3;
    v.exp_sum = e;
    return v;
  endfunction

  function automatic logic [15:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Drivers: every task starts and ends just after a falling edge.
  task automatic do_start(input logic [31:0] b);
    start = 1'b1;
    bias  = b;
    @(negedge clk);
    start = 1'b0;
    check("in_ready_after_start", 32'(bus.in_ready), 32'd1);
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic feed_beats(input beat_arr_t d, input beat_arr_t w, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          bus.in_valid = 1'b0;
          start = ($urandom_range(0, 3) == 0);
          bias  = $urandom;
          @(negedge clk);
        end
      end
      bus.in_valid  = 1'b1;
      bus.in_data   = d[i];
      bus.in_weight = w[i];
      start = gaps && ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    start = 1'b0;
    check("drain_state", 32'(state_dbg), 32'(ST_DRAIN));
    check("drain_in_ready", 32'(bus.in_ready), 32'd0);
    check("drain_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("out_valid_latency2", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic collect(input int hold);
    int n;
    logic [31:0] e;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout: got 0, expected 1 within 20 cycles");
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got a result, expected none");
      return;
    end
    e = exp_q.pop_front();
    check("out_sum", bus.out_sum, e);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_out_sum", bus.out_sum, e);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
    end
  endtask

  task automatic handshake(input bit with_start, input logic [31:0] b);
    bus.out_ready = 1'b1;
    start = with_start;
    if (with_start) bias = b;
    @(negedge clk);
    bus.out_ready = 1'b0;
    start = 1'b0;
    check("out_valid_drop", 32'(bus.out_valid), 32'd0);
    if (with_start) check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
    else            check("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic run_eval(input logic [31:0] b, input beat_arr_t d, input beat_arr_t w,
                          input bit gaps, input int hold);
    do_start(b);
    feed_beats(d, w, gaps);
    collect(hold);
    handshake(1'b0, 32'h0);
  endtask

  // Stimulus and scoreboard
  initial begin
    beat_arr_t rd, rw;
    logic [31:0] rb;

    vecs[0] = mk(32'h0000_0100, 16'd2, 16'd3, 16'd4, 16'd5, 16'hFFFF, 16'd7, 16'd10, 16'd10, 32'h0000_0177);
    vecs[1] = mk(32'h0, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 32'h7FFF_FFFF);
    vecs[2] = mk(32'h0, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 32'h8000_0000);
    vecs[3] = mk(32'hFFFF_FFFB, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 32'hFFFF_FFFF);
    vecs[4] = mk(32'h7FFF_FFF0, 16'd1, 16'd15, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 32'h7FFF_FFFF);
    vecs[5] = mk(32'h7FFF_FFF0, 16'd1, 16'd16, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 32'h7FFF_FFFF);
    vecs[6] = mk(32'h8000_0000, 16'hFFFF, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 32'h8000_0000);
    vecs[7] = mk(32'h0, 16'h8000, 16'h8000, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 32'h4000_0001);
    basic_d = vecs[0].d;
    basic_w = vecs[0].w;

    // Reset
    rst_n = 1'b0;
    start = 1'b0;
    bias  = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_weight = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_sum", bus.out_sum, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors, gap-free
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(vecs[i].exp_sum);
      run_eval(vecs[i].bias, vecs[i].d, vecs[i].w, 1'b0, 0);
    end

    // Randomized evaluations against the model
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 4; i++) begin
        rd[i] = rand_word();
        rw[i] = rand_word();
      end
      case ($urandom_range(0, 2))
        0:       rb = 32'h7FFF_FF00;
        1:       rb = 32'h8000_0100;
        default: rb = $urandom;
      endcase
      exp_q.push_back(ref_sum(rb, rd, rw));
      run_eval(rb, rd, rw, 1'b1, $urandom_range(0, 3));
    end

    // Backpressure: hold the result, ignore start pulses, then chain back-to-back
    exp_q.push_back(32'h0000_0177);
    do_start(32'h0000_0100);
    feed_beats(basic_d, basic_w, 1'b1);
    collect(0);
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      bias  = 32'hDEAD_BEEF;
      @(negedge clk);
      start = 1'b0;
      check("bp_out_sum", bus.out_sum, 32'h0000_0177);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_state", 32'(state_dbg), 32'(ST_OUT));
    end
    exp_q.push_back(32'h0000_1077);
    handshake(1'b1, 32'h0000_1000);
    feed_beats(basic_d, basic_w, 1'b0);
    collect(0);
    handshake(1'b0, 32'h0);

    // Reset after two beats
    do_start(32'h0000_0100);
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'd2;
    bus.in_weight = 16'd3;
    @(negedge clk);
    bus.in_data   = 16'd4;
    bus.in_weight = 16'd5;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_sum", bus.out_sum, 32'h0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(32'h0000_0177);
    run_eval(32'h0000_0100, basic_d, basic_w, 1'b0, 0);

    // Report
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Sequential multiply-accumulate core of a neuron. It streams `num_inputs` signed (input, weight) pairs through a valid/ready handshake and sums their products onto a preloaded bias. It then presents the saturated 2·`data_width` pre-activation sum to the downstream activation stage over a valid/ready handshake. It is the producer side of the double-width accumulator interface that the activation block consumes.

## Interface
- `data_width`, 16, width of signed input and weight words; output is 2·`data_width`
- `num_inputs`, 8, number of (input, weight) beats per neuron evaluation; must be ≥1
- `clk`  in  1  single clock; all logic is on the rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `start`  in  1  begins an evaluation and loads the bias
- `bias`  in  2·data_width  signed bias in product scale, sampled when `start` is accepted
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  core accepts a beat
- `in_data`  in  data_width  signed input activation
- `in_weight`  in  data_width  signed weight
- `out_valid`  out  1  `out_sum` valid
- `out_ready`  in  1  downstream accepts `out_sum`
- `out_sum`  out  2·data_width  saturated signed pre-activation sum
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACC, DRAIN, OUT.
- IDLE
  - `in_ready`=0.
  - `start`=1 loads `acc` with sign-extended `bias`, clears the beat counter, and moves to ACC.
- ACC
  - `in_ready`=1.
  - A beat is accepted on `in_valid`&&`in_ready`. The accepted `in_data`×`in_weight` (signed, 2·data_width) is registered into `prod`, and `prod_vld` is set for one cycle.
  - Each cycle with `prod_vld` set, `acc` += sign-extended `prod`. This runs concurrently with acceptance of the next beat.
  - The counter increments per accepted beat. Acceptance of beat `num_inputs` moves the FSM to DRAIN.
- DRAIN, one cycle
  - `in_ready`=0.
  - `out_sum` <= sat(`acc` + `prod`).
  - Move to OUT.
- OUT
  - `out_valid`=1. `out_sum` is held stable until `out_ready`.
  - On the handshake, go to IDLE. If `start`=1 in the handshake cycle, instead load the bias and go straight to ACC, so evaluations run back-to-back.
- `start` outside IDLE and outside the OUT handshake cycle is ignored.
- Arithmetic
  - `acc` width = 2·data_width + clog2(num_inputs+1) + 1. `acc` never wraps.
  - sat() clamps to [−2^(2·data_width−1), 2^(2·data_width−1)−1]: 0x8000_0000 / 0x7FFF_FFFF at the default width.
  - −2^(dw−1)×−2^(dw−1) = 2^(2dw−2) is representable and needs no special case.
- Reset: any state returns to IDLE, the partial sum is discarded, and there is no residual effect on the next evaluation.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_sum`=0, `busy`=0. Internal state is also cleared: `acc`=0, `prod`=0, `prod_vld`=0, counter=0, state=IDLE.
- `start` accepted at edge E → `in_ready`=1 after E.
- Last beat accepted at edge E0 → DRAIN after E0 → `out_valid`=1 after E0+1, i.e. 2 cycles latency.
- With a gap-free stream, one evaluation takes `num_inputs`+3 cycles including the `start` and handshake cycles.
- `in_ready` is a registered function of state only. It does not depend combinationally on `in_valid`.
- `out_valid`/`out_sum` are registered and do not depend combinationally on `out_ready`.
- Input gaps (`in_valid`=0 in ACC) stall the counter only. A pending `prod` still accumulates.

## Structure
- Shared package `nn_pkg`:
  - FSM state encoding
  - accumulator-width function
  - saturation limit constants
- Sub-module `sat_clamp` (parameterised in/out widths, combinational): wide signed value → clamped 2·data_width. It can be reused by other layers.
- Everything else stays in `neuron_mac`.

## Test plan
All scenarios use `data_width`=16 and `num_inputs`=4.
- Basic: `bias`=0x0000_0100; beats (2,3),(4,5),(−1,7),(10,10) → `out_sum`=0x0000_0177 (375), `out_valid` 2 cycles after beat 4.
- Positive saturation: `bias`=0; 4×(−32768,−32768) → sum 2^32 → `out_sum`=0x7FFF_FFFF.
- Negative saturation: `bias`=0; 4×(32767,−32768) → −4294836224 → `out_sum`=0x8000_0000.
- Backpressure: random `in_valid` gaps, then `out_ready`=0 for 5 cycles.
  - `out_sum` held and `in_ready`=0 throughout.
  - `start` pulses during the hold are ignored.
  - `start`+`out_ready` in the same cycle → next evaluation begins immediately with the correct new bias.
- Reset mid-operation: assert `rst_n`=0 after 2 beats.
  - All outputs go to reset values asynchronously.
  - A subsequent full run of the basic vectors gives 0x0000_0177.
